// File: rtl/sevenseg_pkg.sv
// Shared definitions for the seven-segment scanner: segment font, blank code, index sizing.
package sevenseg_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Common-anode font, bit order {a,b,c,d,e,f,g}, 0 = segment lit.
  function automatic logic [6:0] hex2seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/sevenseg_if.sv
// Display-path bundle: register-side requests into the scanner, pin-side drive out of it.
interface sevenseg_if #(
  parameter int NUM_DIGITS = 8,
  parameter int PWM_BITS   = 4
);
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic [PWM_BITS-1:0]     brightness;
  logic                    freeze;
  logic [NUM_DIGITS-1:0]   an;
  logic [6:0]              seg;
  logic                    dp_n;
  logic                    frame_done;

  modport master (
    output value, dp, digit_en, brightness, freeze,
    input  an, seg, dp_n, frame_done
  );

  modport slave (
    input  value, dp, digit_en, brightness, freeze,
    output an, seg, dp_n, frame_done
  );
endinterface

// File: rtl/sevenseg_lzb.sv
// Combinational leading-zero blank mask; only compiled when SEVSEG_LZB_EN is defined.
`ifdef SEVSEG_LZB_EN
module sevenseg_lzb #(
  parameter int NUM_DIGITS = 8
) (
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  output logic [NUM_DIGITS-1:0]   blank
);

  // lead stays set while every enabled digit above is zero with no decimal point.
  always_comb begin
    logic lead;
    lead  = 1'b1;
    blank = '0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      blank[i] = lead && (value[4*i +: 4] == 4'h0) && !dp[i];
      if (digit_en[i])
        lead = lead && (value[4*i +: 4] == 4'h0) && !dp[i];
    end
  end

endmodule
`endif

// File: rtl/sevenseg_scanner.sv
// Multiplexed common-anode seven-segment scanner with frame-synchronous shadow and PWM dimming.
// Define SEVSEG_LZB_EN to enable leading-zero blanking.
module sevenseg_scanner
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int CLK_DIV    = 50000,
  parameter int PWM_BITS   = 4
) (
  input logic        clk,
  input logic        Rst,
  sevenseg_if.slave  bus
);

  localparam int IDX_W  = idx_width(NUM_DIGITS);
  localparam int SLOT_W = $clog2(CLK_DIV);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(CLK_DIV - 1);

  if (NUM_DIGITS < 1 || NUM_DIGITS > 16) begin : g_bad_digits
    $error("sevenseg_scanner: NUM_DIGITS must be in 1..16");
  end
  if (CLK_DIV < (2 ** PWM_BITS)) begin : g_bad_div
    $error("sevenseg_scanner: CLK_DIV must be >= 2**PWM_BITS");
  end

  logic [IDX_W-1:0]        idx_p0;
  logic [SLOT_W-1:0]       slot_p0;
  logic [PWM_BITS-1:0]     pwm_p0;
  logic [4*NUM_DIGITS-1:0] sh_val_p0;
  logic [NUM_DIGITS-1:0]   sh_dp_p0;
  logic [NUM_DIGITS-1:0]   sh_en_p0;
  logic [NUM_DIGITS-1:0]   sh_blank_p0;
  logic [NUM_DIGITS-1:0]   blank_nxt;

  logic [NUM_DIGITS-1:0]   an_p1;
  logic [6:0]              seg_p1;
  logic                    dp_n_p1;
  logic                    frame_done_p1;

  logic slot_tc, frame_wrap;
  assign slot_tc    = (slot_p0 == SLOT_LAST);
  assign frame_wrap = slot_tc && (idx_p0 == IDX_LAST);

`ifdef SEVSEG_LZB_EN
  sevenseg_lzb #(.NUM_DIGITS(NUM_DIGITS)) u_lzb (
    .value    (bus.value),
    .dp       (bus.dp),
    .digit_en (bus.digit_en),
    .blank    (blank_nxt)
  );
`else
  assign blank_nxt = '0;
`endif

  // ---- stage p0: scan counters and frame shadow ----
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      idx_p0      <= '0;
      slot_p0     <= '0;
      pwm_p0      <= '0;
      sh_val_p0   <= '0;
      sh_dp_p0    <= '0;
      sh_en_p0    <= '0;
      sh_blank_p0 <= '0;
    end else begin
      pwm_p0 <= pwm_p0 + PWM_BITS'(1);
      if (slot_tc) begin
        slot_p0 <= '0;
        idx_p0  <= (idx_p0 == IDX_LAST) ? '0 : idx_p0 + IDX_W'(1);
      end else begin
        slot_p0 <= slot_p0 + SLOT_W'(1);
      end
      if (frame_wrap && !bus.freeze) begin
        sh_val_p0   <= bus.value;
        sh_dp_p0    <= bus.dp;
        sh_en_p0    <= bus.digit_en;
        sh_blank_p0 <= blank_nxt;
      end
    end
  end

  logic                  pwm_on, dig_vis, dig_lit;
  logic [3:0]            cur_nib;
  logic [NUM_DIGITS-1:0] an_nxt;
  logic [6:0]            seg_nxt;
  logic                  dp_n_nxt;

  always_comb begin
    pwm_on   = (bus.brightness == '1) || (pwm_p0 < bus.brightness);
    cur_nib  = sh_val_p0[4*idx_p0 +: 4];
    dig_vis  = sh_en_p0[idx_p0] && !sh_blank_p0[idx_p0];
    dig_lit  = pwm_on && dig_vis;
    an_nxt   = '1;
    if (dig_lit)
      an_nxt = ~(NUM_DIGITS'(1) << idx_p0);
    seg_nxt  = dig_vis ? hex2seg(cur_nib) : SEG_OFF;
    dp_n_nxt = dig_lit ? ~sh_dp_p0[idx_p0] : 1'b1;
  end

  // ---- stage p1: registered pin drive ----
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      an_p1         <= '1;
      seg_p1        <= SEG_OFF;
      dp_n_p1       <= 1'b1;
      frame_done_p1 <= 1'b0;
    end else begin
      an_p1         <= an_nxt;
      seg_p1        <= seg_nxt;
      dp_n_p1       <= dp_n_nxt;
      frame_done_p1 <= frame_wrap;
    end
  end

  assign bus.an         = an_p1;
  assign bus.seg        = seg_p1;
  assign bus.dp_n       = dp_n_p1;
  assign bus.frame_done = frame_done_p1;

endmodule

// File: tb/tb_sevenseg_scanner.sv
// Bench for sevenseg_scanner (4 digits, 16 clocks/slot, 2-bit PWM) against a cycle-count reference model.
module tb_sevenseg_scanner;

  logic clk = 1'b0;
  logic Rst;
  always #5 clk = ~clk;

  sevenseg_if #(.NUM_DIGITS(4), .PWM_BITS(2)) bus ();

  sevenseg_scanner #(.NUM_DIGITS(4), .CLK_DIV(16), .PWM_BITS(2)) dut (
    .clk (clk),
    .Rst (Rst),
    .bus (bus.slave)
  );

  logic [6:0] font [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                           7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                           7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                           7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  int tests = 0;
  int fails = 0;
  int n;
  logic [15:0] m_val;
  logic [3:0]  m_dp, m_en, m_blank;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] ref_blank(input logic [15:0] v, input logic [3:0] d, input logic [3:0] e);
    logic [3:0] b;
    b = '0;
`ifdef SEVSEG_LZB_EN
    for (int i = 1; i < 4; i++) begin
      bit ok;
      ok = (v[4*i +: 4] == 4'h0) && !d[i];
      for (int j = i + 1; j < 4; j++)
        if (e[j] && (v[4*j +: 4] != 4'h0 || d[j])) ok = 1'b0;
      b[i] = ok;
    end
`endif
    return b;
  endfunction

  task automatic model_reset();
    n = 0; m_val = '0; m_dp = '0; m_en = '0; m_blank = '0;
  endtask

  // One clock: predict the output for edge n from the state after edge n-1, then check at +1.
  task automatic step();
    int s, idx;
    bit on, vis, lit;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic e_dpn, e_fd;
    @(posedge clk);
    n++;
    s   = n - 1;
    idx = (s / 16) % 4;
    on  = (bus.brightness == 2'd3) || ((s % 4) < int'(bus.brightness));
    vis = m_en[idx] && !m_blank[idx];
    lit = on && vis;
    e_an  = lit ? ~(4'b0001 << idx) : 4'hF;
    e_seg = vis ? font[m_val[4*idx +: 4]] : 7'h7F;
    e_dpn = lit ? ~m_dp[idx] : 1'b1;
    e_fd  = (s % 64 == 63);
    if (n % 64 == 0 && !bus.freeze) begin
      m_val   = bus.value;
      m_dp    = bus.dp;
      m_en    = bus.digit_en;
      m_blank = ref_blank(bus.value, bus.dp, bus.digit_en);
    end
    #1;
    chk($sformatf("an@%0d", n), 32'(bus.an), 32'(e_an));
    chk($sformatf("seg@%0d", n), 32'(bus.seg), 32'(e_seg));
    chk($sformatf("dp_n@%0d", n), 32'(bus.dp_n), 32'(e_dpn));
    chk($sformatf("frame_done@%0d", n), 32'(bus.frame_done), 32'(e_fd));
  endtask

  task automatic run(input int cycles);
    for (int k = 0; k < cycles; k++) step();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_an"}, 32'(bus.an), 32'h0000000F);
    chk({tag, "_seg"}, 32'(bus.seg), 32'h0000007F);
    chk({tag, "_dp_n"}, 32'(bus.dp_n), 32'h00000001);
    chk({tag, "_fd"}, 32'(bus.frame_done), 32'h00000000);
  endtask

  initial begin
    Rst = 1'b1;
    bus.value = 16'h1234; bus.dp = 4'h0; bus.digit_en = 4'hF;
    bus.brightness = 2'd3; bus.freeze = 1'b0;
    #2;
    check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    Rst = 1'b0;
    model_reset();

    // scan order, with the first frame dark
    run(4 * 64);

    // value change mid-frame, then freeze holds the old shadow
    run(30);
    bus.value = 16'hABCD;
    run(34 + 128);
    bus.freeze = 1'b1;
    bus.value  = 16'h5A5A;
    run(128);
    bus.freeze = 1'b0;
    run(64);

    // PWM duty
    bus.brightness = 2'd1;
    run(128);
    bus.brightness = 2'd0;
    run(64);
    bus.brightness = 2'd2;
    run(64);
    bus.brightness = 2'd3;

    // enable mask and decimal point
    bus.digit_en = 4'b0101; bus.dp = 4'b0001;
    run(128);

    // leading zeros
    bus.digit_en = 4'hF; bus.dp = 4'h0; bus.value = 16'h0040;
    run(128);
    bus.digit_en = 4'b0111; bus.value = 16'h5000;
    run(128);

    // randomized inputs changing at arbitrary cycles
    for (int k = 0; k < 1600; k++) begin
      case ($urandom_range(0, 15))
        0: bus.value      = 16'($urandom);
        1: bus.value      = 16'($urandom_range(0, 255)) << (4 * $urandom_range(0, 2));
        2: bus.dp         = 4'($urandom);
        3: bus.digit_en   = 4'($urandom);
        4: bus.brightness = 2'($urandom);
        5: bus.freeze     = ($urandom_range(0, 3) == 0);
        default: ;
      endcase
      step();
    end
    bus.freeze = 1'b0;

    // asynchronous reset between clock edges
    run(37);
    #3;
    Rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst_held");
    @(negedge clk);
    Rst = 1'b0;
    model_reset();
    bus.value = 16'h9876; bus.digit_en = 4'hF; bus.dp = 4'b1000; bus.brightness = 2'd3;
    run(3 * 64);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sevenseg_scanner.md
# sevenseg_scanner

Parametrised multiplexed seven-segment display driver for the MMIO display path. It takes a packed hexadecimal value, per-digit decimal points and a digit-enable mask, and time-multiplexes them onto a common-anode display. Features over the fixed 8-digit scanner: configurable digit count and refresh rate, tear-free frame-synchronous latching, PWM brightness and optional leading-zero blanking. Sits between the debug-display register and the board pins.

## Interface
Parameters:
- NUM_DIGITS, 8, digits scanned; legal range 1..16
- CLK_DIV, 50000, clocks per digit slot; must be >= 2**PWM_BITS
- PWM_BITS, 4, brightness resolution in bits

Ports:
- clk  in  1  system clock
- Rst  in  1  reset, asynchronous, active-high
- value  in  4*NUM_DIGITS  hex nibbles; nibble i drives digit i (digit 0 rightmost)
- dp  in  NUM_DIGITS  decimal point request per digit, 1 = lit
- digit_en  in  NUM_DIGITS  1 = digit may be lit
- brightness  in  PWM_BITS  duty control
- freeze  in  1  1 = hold the current shadow and do not relatch at frame boundary
- an  out  NUM_DIGITS  anode enables, active-low, one-hot-low or all-ones
- seg  out  7  segments {a,b,c,d,e,f,g}, active-low
- dp_n  out  1  decimal point, active-low
- frame_done  out  1  one-cycle pulse at each frame wrap

## Operation
- Reset values: an all ones, seg 7'h7F, dp_n 1, frame_done 0; digit index 0, slot counter 0, PWM counter 0; shadow value/dp/en/blank all 0.
- slot_cnt counts 0..CLK_DIV-1. At terminal count it wraps to 0 and the index advances; NUM_DIGITS-1 wraps to 0.
- Frame wrap (index NUM_DIGITS-1 -> 0 at terminal count):
  - frame_done pulses.
  - Unless freeze=1, value, dp and digit_en are latched into the shadow, and the blank mask is recomputed.
  - Inputs have no effect mid-frame.
- pwm_cnt free-runs mod 2**PWM_BITS, every clock.
- Display is on when brightness == all-ones, or when pwm_cnt < brightness. brightness 0 means fully dark.
- For current index i: an[i] = 0 only if on, shadow_en[i] = 1 and blank[i] = 0. All other anodes are 1.
- seg is the font of shadow nibble i. It is 7'h7F when digit i is blanked or disabled.
- dp_n = ~shadow_dp[i]. It is forced to 1 when the digit is dark.
- Font, nibbles 0..F:
  - 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111
  - 0000000, 0000100, 0001000, 1100000, 0110001, 1000010, 0110000, 0111000
- Disabled digits still consume their slot, so frame period is constant.
- Reset mid-frame: all state returns to reset values immediately and asynchronously. The display is dark until the first frame wrap latches inputs.

## Timing
- Digit slot = CLK_DIV clocks; frame = NUM_DIGITS*CLK_DIV clocks.
- an, seg, dp_n, frame_done are registered. They reflect index/counter state with 1 clock latency.
- First latch occurs NUM_DIGITS*CLK_DIV clocks after reset release. Outputs show the new shadow 1 clock later.
- Index width is max(1, $clog2(NUM_DIGITS)). slot_cnt width is $clog2(CLK_DIV).
- NUM_DIGITS=1: the index stays 0, and frame_done pulses every CLK_DIV clocks.

## Configuration
- SEVSEG_LZB_EN defined: leading-zero blanking.
  - blank[i] = 1 for i > 0 when nibble i and every enabled higher nibble are 0.
  - Disabled digits are ignored in that test.
  - Digit 0 is never blanked.
  - A lit dp on a digit stops blanking at and below that digit.
- SEVSEG_LZB_EN undefined: blank mask is constant 0. The mask logic is not synthesised.

## Structure
- Package sevenseg_pkg holds:
  - the font as a function hex2seg(logic [3:0]) returning logic [6:0];
  - the constant SEG_OFF = 7'h7F.
- One sub-module, sevenseg_lzb, is a combinational blank-mask generator, instantiated only under SEVSEG_LZB_EN.
- Elaboration assertions:
  - NUM_DIGITS in 1..16;
  - CLK_DIV >= 2**PWM_BITS.

## Test plan
Bench parameters: NUM_DIGITS=4, CLK_DIV=16, PWM_BITS=2; brightness=3 unless stated.
- Scan order: value=16'h1234, dp=0, digit_en=4'hF, after first frame:
  - an cycles 1110, 1101, 1011, 0111, 16 clocks each;
  - seg = 1001100, 0000110, 0010010, 1001111;
  - frame_done every 64 clocks.
- Tear-free latch: change value to 16'hABCD at mid-frame.
  - Current frame still shows 1234.
  - Next frame shows D, C, B, A.
  - With freeze=1 held, 1234 persists.
- PWM: brightness=1. Each slot's anode is low only on clocks where pwm_cnt==0, i.e. 4 of 16 clocks. brightness=0 keeps an=4'hF always.
- Enable/dp: digit_en=4'b0101, dp=4'b0001.
  - Digits 1 and 3 stay dark, but their slots last 16 clocks.
  - dp_n = 0 only during digit 0.
- LZB with SEVSEG_LZB_EN, value=16'h0040:
  - digits 3 and 2 are dark; digit 1 shows 4; digit 0 shows 0.
  - Without the macro, all four digits are lit.
- Async reset: assert Rst mid-slot with no clock edge. an=4'hF, seg=7'h7F, dp_n=1 immediately. After release, the display stays dark until 64 clocks have elapsed.
